// File: rtl/fp_pkg.sv
// Shared floating-point definitions: adder status codes, value classes and
// IEEE-754 single-precision field constants.
package fp_pkg;

    typedef enum logic [1:0] {
        OVF_NONE    = 2'b00,
        OVF_OVER    = 2'b01,
        OVF_UNDER   = 2'b10,
        OVF_INVALID = 2'b11
    } ovf_e;

    typedef enum logic [2:0] {
        CLS_ZERO = 3'b000,
        CLS_SUB  = 3'b001,
        CLS_NORM = 3'b010,
        CLS_INF  = 3'b011,
        CLS_NAN  = 3'b100
    } cls_e;

    localparam int unsigned EXP_W   = 8;
    localparam int unsigned FRAC_W  = 23;
    localparam logic [EXP_W-1:0] EXP_MAX = 8'd255;

    // Field masks over the full word, sign excluded.
    localparam logic [31:0] EXP_MASK  = {1'b0, EXP_MAX, {FRAC_W{1'b0}}};
    localparam logic [31:0] FRAC_MASK = {{(EXP_W + 1){1'b0}}, {FRAC_W{1'b1}}};

endpackage

// File: rtl/fp_classify.sv
// Combinational IEEE-754 single-precision classifier; the sign bit is ignored.
module fp_classify
    import fp_pkg::*;
(
    input  logic [31:0] in_z,
    output logic [2:0]  cls
);

    logic exp_zero;
    logic exp_max;
    logic frac_zero;

    always_comb begin
        exp_zero  = (in_z & EXP_MASK) == '0;
        exp_max   = (in_z & EXP_MASK) == EXP_MASK;
        frac_zero = (in_z & FRAC_MASK) == '0;
        cls       = CLS_NORM;
        if (exp_zero) begin
            cls = frac_zero ? CLS_ZERO : CLS_SUB;
        end else if (exp_max) begin
            cls = frac_zero ? CLS_INF : CLS_NAN;
        end
    end

endmodule

// File: rtl/fp_result_buffer.sv
// Show-ahead result FIFO behind the FP adder with sticky exception flags and a
// saturating error counter. Define FP_CLASSIFY_EN to store a class per entry.
module fp_result_buffer
    import fp_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 8
)
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              in_z,
    input  logic [1:0]               in_ovf,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_z,
    output logic [1:0]               out_ovf,
`ifdef FP_CLASSIFY_EN
    output logic [2:0]               out_class,
`endif
    input  logic                     clear_sticky,
    output logic [2:0]               sticky,
    output logic [CNT_W-1:0]         err_count,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic [2:0]       sticky_q, sticky_d;
    logic [CNT_W-1:0] err_q, err_d;
    logic             push, pop;

    logic [31:0] mem_z_q   [DEPTH];
    logic [1:0]  mem_ovf_q [DEPTH];

`ifdef FP_CLASSIFY_EN
    logic [2:0] in_cls;
    logic [2:0] mem_cls_q [DEPTH];

    fp_classify u_classify (
        .in_z (in_z),
        .cls  (in_cls)
    );

    assign out_class = mem_cls_q[rd_ptr_q];
`endif

    assign in_ready  = level_q != LVL_W'(DEPTH);
    assign out_valid = level_q != '0;
    assign out_z     = mem_z_q[rd_ptr_q];
    assign out_ovf   = mem_ovf_q[rd_ptr_q];
    assign sticky    = sticky_q;
    assign err_count = err_q;
    assign level     = level_q;

    always_comb begin
        push     = in_valid && in_ready;
        pop      = out_valid && out_ready;
        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        level_d  = level_q;
        case ({push, pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase

        // Clear is applied first so a same-cycle error push survives it.
        sticky_d = clear_sticky ? '0 : sticky_q;
        err_d    = clear_sticky ? '0 : err_q;
        if (push) begin
            case (ovf_e'(in_ovf))
                OVF_OVER:    sticky_d[0] = 1'b1;
                OVF_UNDER:   sticky_d[1] = 1'b1;
                OVF_INVALID: sticky_d[2] = 1'b1;
                default:     ;
            endcase
            if (in_ovf != OVF_NONE && err_d != '1) begin
                err_d = err_d + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            sticky_q <= '0;
            err_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            sticky_q <= sticky_d;
            err_q    <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_z_q[wr_ptr_q]   <= in_z;
            mem_ovf_q[wr_ptr_q] <= in_ovf;
`ifdef FP_CLASSIFY_EN
            mem_cls_q[wr_ptr_q] <= in_cls;
`endif
        end
    end

endmodule

// File: tb/tb_fp_result_buffer.sv
// Scoreboard bench for fp_result_buffer: a queue-based reference model checks
// occupancy, handshakes, head data, sticky flags and the error counter.
module tb_fp_result_buffer;

    localparam int DEPTH = 4;
    localparam int CNT_W = 8;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       in_z;
    logic [1:0]        in_ovf;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_z;
    logic [1:0]        out_ovf;
`ifdef FP_CLASSIFY_EN
    logic [2:0]        out_class;
`endif
    logic              clear_sticky;
    logic [2:0]        sticky;
    logic [CNT_W-1:0]  err_count;
    logic [$clog2(DEPTH):0] level;

    fp_result_buffer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_z         (in_z),
        .in_ovf       (in_ovf),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_z        (out_z),
        .out_ovf      (out_ovf),
`ifdef FP_CLASSIFY_EN
        .out_class    (out_class),
`endif
        .clear_sticky (clear_sticky),
        .sticky       (sticky),
        .err_count    (err_count),
        .level        (level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] z;
        logic [1:0]  ovf;
    } ent_t;

    ent_t        q[$];
    logic [2:0]  m_sticky;
    int          m_cnt;
    int          n_checks;
    int          n_pass;

    function automatic logic [2:0] ref_class(logic [31:0] z);
        int e;
        int f;
        e = int'(z[30:23]);
        f = int'(z[22:0]);
        if (e == 0)   return (f == 0) ? 3'd0 : 3'd1;
        if (e == 255) return (f == 0) ? 3'd3 : 3'd4;
        return 3'd2;
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: checks state seen before each edge, then applies the edge.
    always @(negedge clk) begin
        bit acc_push;
        bit acc_pop;
        ent_t e;
        if (rst) begin
            q.delete();
            m_sticky = '0;
            m_cnt = 0;
        end else begin
            check("level", 64'(level), 64'(q.size()));
            check("in_ready", 64'(in_ready), 64'(q.size() != DEPTH));
            check("out_valid", 64'(out_valid), 64'(q.size() != 0));
            check("sticky", 64'(sticky), 64'(m_sticky));
            check("err_count", 64'(err_count), 64'(m_cnt));
            if (q.size() != 0) begin
                check("out_z", 64'(out_z), 64'(q[0].z));
                check("out_ovf", 64'(out_ovf), 64'(q[0].ovf));
`ifdef FP_CLASSIFY_EN
                check("out_class", 64'(out_class), 64'(ref_class(q[0].z)));
`endif
            end
            acc_push = in_valid && (q.size() < DEPTH);
            acc_pop  = out_ready && (q.size() > 0);
            if (acc_pop) void'(q.pop_front());
            if (clear_sticky) begin
                m_sticky = '0;
                m_cnt = 0;
            end
            if (acc_push) begin
                e.z = in_z;
                e.ovf = in_ovf;
                q.push_back(e);
                if (in_ovf != 2'b00) begin
                    m_sticky[int'(in_ovf) - 1] = 1'b1;
                    if (m_cnt < CNT_MAX) m_cnt++;
                end
            end
        end
    end

    task automatic drive(bit v, logic [31:0] z, logic [1:0] o, bit r, bit c);
        @(posedge clk);
        #1;
        in_valid = v;
        in_z = z;
        in_ovf = o;
        out_ready = r;
        clear_sticky = c;
    endtask

    task automatic idle();
        drive(1'b0, 32'h0, 2'b00, 1'b0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        n_checks = 0;
        n_pass = 0;
        m_sticky = '0;
        m_cnt = 0;
        rst = 1'b1;
        in_valid = 1'b0;
        in_z = '0;
        in_ovf = '0;
        out_ready = 1'b0;
        clear_sticky = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;

        // Single push into empty buffer
        drive(1, 32'h3F800000, 2'b00, 0, 0);
        idle();
        #3;
        check("single_valid", 64'(out_valid), 64'd1);
        check("single_z", 64'(out_z), 64'h3F800000);
`ifdef FP_CLASSIFY_EN
        check("single_class", 64'(out_class), 64'd2);
`endif

        // Fill to full, extra pushes ignored, drain, wrap
        drive(1, 32'h40000000, 2'b00, 0, 0);
        drive(1, 32'h40400000, 2'b00, 0, 0);
        drive(1, 32'h40800000, 2'b00, 0, 0);
        drive(1, 32'hDEADBEEF, 2'b00, 0, 0);
        drive(1, 32'hDEADBEEF, 2'b00, 0, 0);
        idle();
        #3;
        check("full_level", 64'(level), 64'(DEPTH));
        check("full_in_ready", 64'(in_ready), 64'd0);
        repeat (5) drive(0, 32'h0, 2'b00, 1, 0);
        drive(1, 32'h11111111, 2'b00, 0, 0);
        drive(1, 32'h22222222, 2'b00, 0, 0);
        repeat (3) drive(0, 32'h0, 2'b00, 1, 0);

        // Sticky flags and counter
        drive(1, 32'h7F800000, 2'b01, 0, 0);
        drive(1, 32'h00000001, 2'b10, 0, 0);
        drive(1, 32'h7FC00000, 2'b11, 0, 0);
        idle();
        #3;
        check("sticky_all", 64'(sticky), 64'b111);
        check("err_three", 64'(err_count), 64'd3);
        repeat (4) drive(0, 32'h0, 2'b00, 1, 0);

        // Clear colliding with an overflow push
        drive(1, 32'h7F800000, 2'b01, 1, 1);
        idle();
        #3;
        check("clear_sticky", 64'(sticky), 64'b001);
        check("clear_err", 64'(err_count), 64'd1);

        // Counter saturation
        for (int i = 0; i < 300; i++)
            drive(1, $urandom, 2'($urandom_range(1, 3)), 1, 0);
        drive(0, 32'h0, 2'b00, 1, 0);
        idle();
        #3;
        check("err_saturate", 64'(err_count), 64'(CNT_MAX));

        // Simultaneous push/pop at level 2, then at full
        drive(1, $urandom, 2'b00, 0, 0);
        drive(1, $urandom, 2'b00, 0, 0);
        for (int i = 0; i < 10; i++)
            drive(1, $urandom, 2'($urandom_range(0, 3)), 1, 0);
        idle();
        #3;
        check("pushpop_level", 64'(level), 64'd2);
        drive(1, $urandom, 2'b00, 0, 0);
        drive(1, $urandom, 2'b00, 0, 0);
        drive(1, 32'hCAFEF00D, 2'b00, 1, 0);
        idle();
        #3;
        check("full_pushpop_level", 64'(level), 64'(DEPTH - 1));

        // Asynchronous reset mid-stream with level 3 and non-zero flags
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_level", 64'(level), 64'd0);
        check("rst_sticky", 64'(sticky), 64'd0);
        check("rst_err", 64'(err_count), 64'd0);
        @(posedge clk);
        #2 rst = 1'b0;

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            logic [31:0] z;
            case ($urandom_range(0, 5))
                0: z = 32'h00000000;
                1: z = 32'h80000001;
                2: z = 32'hFF800000;
                3: z = 32'h7F800001;
                default: z = $urandom;
            endcase
            drive(1'($urandom_range(0, 1)), z, 2'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), $urandom_range(0, 15) == 0);
        end
        idle();
        repeat (2) @(posedge clk);
        #3;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
